// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle processor control unit:
// opcodes, FSM state encoding, mux select codes and the control vector.
package mc_ctrl_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW    = 3'b001;
  localparam logic [2:0] OP_SW    = 3'b010;
  localparam logic [2:0] OP_BEQ   = 3'b011;
  localparam logic [2:0] OP_J     = 3'b100;
  localparam logic [2:0] OP_ADDI  = 3'b101;
  localparam logic [2:0] OP_UNDEF = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_TWO  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_SHL  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       alu_src_a;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the control unit (master) and the datapath (slave).
interface multicycle_control_if;
  logic [2:0]  opcode;
  logic [1:0]  ALUOp;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic        RegDst;
  logic        MemtoReg;
  logic        MemRead;
  logic        MemWrite;
  logic        IorD;
  logic        RegWrite;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        ALUSrcA;
  logic        halted;
  logic        illegal;
  logic [15:0] instr_count;
  logic [3:0]  state_dbg;

  modport master (
    input  opcode,
    output ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite,
           IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
           halted, illegal, instr_count, state_dbg
  );

  modport slave (
    output opcode,
    input  ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite,
           IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
           halted, illegal, instr_count, state_dbg
  );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// Combinational state -> control-vector decode (Moore outputs).
module ctrl_output_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src_b = SRCB_TWO;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE:  ctrl.alu_src_b = SRCB_SHL;
      S_MEMADR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_RWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      default:   ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the 16-bit multi-cycle processor: state register,
// next-state logic, retired-instruction counter and halt/illegal flags.
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  multicycle_control_if.master  bus
);

  state_t      state_q;
  state_t      state_d;
  logic        illegal_q;
  logic [15:0] count_q;
  logic        retire;
  ctrl_t       ctrl;

  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE: state_d = S_EXEC;
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          OP_ADDI:  state_d = S_ADDI_EX;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXEC:    state_d = S_RWB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB:
                 state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_INIT;
    endcase
  end

  // Every final state of an instruction retires it on the edge that leaves it.
  assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWR) ||
                  (state_q == S_RWB)   || (state_q == S_BRANCH) ||
                  (state_q == S_JUMP)  || (state_q == S_ADDI_WB);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && bus.opcode == OP_UNDEF)
        illegal_q <= 1'b1;
      if (retire)
        count_q <= count_q + 16'd1;
    end
  end

  ctrl_output_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: per-state strobe vectors,
// instruction cycle counts, illegal/halt flags, reset and counter wrap.
module tb_multicycle_control;

  // {ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite, IorD,
  //  RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA}
  localparam logic [15:0] V_ZERO   = 16'h0000;
  localparam logic [15:0] V_FETCH  = 16'h108C;
  localparam logic [15:0] V_DEC    = 16'h3000;
  localparam logic [15:0] V_MEMADR = 16'h2001;
  localparam logic [15:0] V_MEMRD  = 16'h00A0;
  localparam logic [15:0] V_MEMWB  = 16'h0110;
  localparam logic [15:0] V_MEMWR  = 16'h0060;
  localparam logic [15:0] V_EXEC   = 16'h8001;
  localparam logic [15:0] V_RWB    = 16'h0210;
  localparam logic [15:0] V_BRANCH = 16'h4403;
  localparam logic [15:0] V_JUMP   = 16'h0804;
  localparam logic [15:0] V_ADDIEX = 16'h2001;
  localparam logic [15:0] V_ADDIWB = 16'h0010;

  logic        clock;
  logic        reset_n;
  logic [15:0] vec;
  int          errors;
  int          checks;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign vec = {bus.ALUOp, bus.ALUSrcB, bus.PCSource, bus.RegDst, bus.MemtoReg,
                bus.MemRead, bus.MemWrite, bus.IorD, bus.RegWrite, bus.IRWrite,
                bus.PCWrite, bus.PCWriteCond, bus.ALUSrcA};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Starts at a FETCH negedge; seq holds one expected vector per cycle, FETCH first.
  task automatic exec_instr(input string name, input logic [2:0] op, input int n,
                            input logic [95:0] seq);
    bus.opcode = op;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_c%0d", name, i), vec, seq[16*i +: 16]);
      step();
    end
    chk({name, "_refetch"}, vec, V_FETCH);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset_n    = 1'b0;
    bus.opcode = 3'b000;
    repeat (3) @(negedge clock);
    chk("rst_vec", vec, V_ZERO);
    chk("rst_cnt", bus.instr_count, 16'h0000);
    chk("rst_flags", {14'd0, bus.illegal, bus.halted}, 16'h0000);

    reset_n = 1'b1;
    chk("init_vec", vec, V_ZERO);
    step();
    chk("fetch_vec", vec, V_FETCH);

    exec_instr("R",    3'b000, 4, {V_RWB, V_EXEC, V_DEC, V_FETCH});
    exec_instr("LW",   3'b001, 5, {V_MEMWB, V_MEMRD, V_MEMADR, V_DEC, V_FETCH});
    exec_instr("SW",   3'b010, 4, {V_MEMWR, V_MEMADR, V_DEC, V_FETCH});
    exec_instr("BEQ",  3'b011, 3, {V_BRANCH, V_DEC, V_FETCH});
    exec_instr("J",    3'b100, 3, {V_JUMP, V_DEC, V_FETCH});
    exec_instr("ADDI", 3'b101, 4, {V_ADDIWB, V_ADDIEX, V_DEC, V_FETCH});
    chk("cnt_after6", bus.instr_count, 16'd6);
    chk("illegal_clear", {15'd0, bus.illegal}, 16'd0);

    exec_instr("UNDEF", 3'b110, 2, {V_DEC, V_FETCH});
    chk("illegal_set", {15'd0, bus.illegal}, 16'd1);
    chk("cnt_undef", bus.instr_count, 16'd6);
    exec_instr("R2", 3'b000, 4, {V_RWB, V_EXEC, V_DEC, V_FETCH});
    chk("illegal_sticky", {15'd0, bus.illegal}, 16'd1);
    chk("cnt_after_r2", bus.instr_count, 16'd7);

    // LW interrupted by reset during write-back
    bus.opcode = 3'b001;
    repeat (4) step();
    chk("lw_memwb", vec, V_MEMWB);
    reset_n = 1'b0;
    #1;
    chk("midrst_vec", vec, V_ZERO);
    chk("midrst_cnt", bus.instr_count, 16'd0);
    chk("midrst_illegal", {15'd0, bus.illegal}, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    chk("restart_init", vec, V_ZERO);
    step();
    chk("restart_fetch", vec, V_FETCH);

    // counter wrap: preset to FFFF while in FETCH, then retire one ADDI
    force dut.count_q = 16'hFFFF;
    bus.opcode = 3'b101;
    step();
    release dut.count_q;
    chk("wrap_dec", vec, V_DEC);
    chk("wrap_pre", bus.instr_count, 16'hFFFF);
    step();
    step();
    chk("wrap_addiwb", vec, V_ADDIWB);
    chk("wrap_hold", bus.instr_count, 16'hFFFF);
    step();
    chk("wrap_fetch", vec, V_FETCH);
    chk("wrap_zero", bus.instr_count, 16'h0000);

    // HALT
    bus.opcode = 3'b111;
    step();
    chk("halt_dec", vec, V_DEC);
    step();
    bus.opcode = 3'b000;
    for (int i = 0; i < 22; i++) begin
      chk($sformatf("halt_flag_%0d", i), {15'd0, bus.halted}, 16'd1);
      chk($sformatf("halt_vec_%0d", i), vec, V_ZERO);
      step();
    end
    chk("halt_cnt", bus.instr_count, 16'h0000);
    reset_n = 1'b0;
    #1;
    chk("halt_rst_flag", {15'd0, bus.halted}, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    chk("halt_rst_init", vec, V_ZERO);
    step();
    chk("halt_rst_fetch", vec, V_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the 16-bit multi-cycle processor. It is a Moore state machine that takes the 3-bit opcode from the datapath's instruction register and drives every datapath control strobe (PC, memory, IR, register file, ALU muxes) for each cycle of fetch, decode, execute, memory and write-back. It also provides a retired-instruction counter, a halt state and a sticky illegal-opcode flag for the testbench and debug.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  3  IR[15:13] from the datapath.
- ALUOp  out  2  00 add, 01 subtract, 10 use function field.
- ALUSrcB  out  2  00 reg B, 01 const 2, 10 sign-extended offset, 11 offset<<1.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump address.
- RegDst, MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA  out  1 each  datapath strobes, same meaning as the datapath ports.
- halted  out  1  high while in HALT.
- illegal  out  1  sticky; set on an undefined opcode.
- instr_count  out  16  number of retired instructions.
- state_dbg  out  4  current state encoding.

## Operation
- Opcodes: 000 R-type, 001 LW, 010 SW, 011 BEQ, 100 J, 101 ADDI, 110 undefined, 111 HALT.
- States and their asserted outputs. Every unlisted output is 0.
  - INIT: all outputs 0. Next: FETCH.
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01. Next: DECODE.
  - DECODE: ALUSrcB=11 (branch target goes into ALUOut). Next state by opcode: 001/010 → MEMADR, 000 → EXEC, 011 → BRANCH, 100 → JUMP, 101 → ADDI_EX, 111 → HALT, 110 → FETCH with illegal set.
  - MEMADR: ALUSrcA, ALUSrcB=10. Next: MEMRD for LW, MEMWR for SW. Uses the opcode held in IR.
  - MEMRD: MemRead, IorD. Next: MEMWB.
  - MEMWB: RegWrite, MemtoReg (RegDst=0). Next: FETCH.
  - MEMWR: MemWrite, IorD. Next: FETCH.
  - EXEC: ALUSrcA, ALUOp=10. Next: RWB.
  - RWB: RegDst, RegWrite. Next: FETCH.
  - BRANCH: ALUSrcA, ALUOp=01, PCWriteCond, PCSource=01. Next: FETCH.
  - JUMP: PCWrite, PCSource=10. Next: FETCH.
  - ADDI_EX: ALUSrcA, ALUSrcB=10. Next: ADDI_WB.
  - ADDI_WB: RegWrite (RegDst=0, MemtoReg=0). Next: FETCH.
  - HALT: all strobes 0, halted=1. Stays in HALT until reset.
- Retire: instr_count increments by 1 on every clock edge leaving MEMWB, MEMWR, RWB, BRANCH, JUMP or ADDI_WB.
  - Undefined opcodes and HALT do not count.
  - The counter is 16-bit and wraps from FFFF to 0000.
- illegal stays 1 once set, until reset.
- The state register is binary-encoded, 4 bits.
  - Unused encodings go to INIT on the next edge, with all outputs 0 while in them.

## Timing
- Reset values: state=INIT, every output 0, instr_count=0, illegal=0, halted=0.
- Reset assertion acts immediately (asynchronous), including mid-instruction.
  - The outputs fall to 0 combinationally, with no partial write-back strobe.
  - Only register-file or memory writes already clocked on earlier edges remain.
- After reset_n deasserts: first edge moves to FETCH; the first fetch strobes appear in the next cycle.
- Outputs are a pure function of the state register, with no combinational path from opcode.
  - opcode is sampled only on the edge leaving DECODE and the edge leaving MEMADR.
- Cycle counts from FETCH back to FETCH: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4, undefined 2.

## Structure
- Package mc_ctrl_pkg holds:
  - opcode localparams (OP_RTYPE…OP_HALT);
  - the state encoding;
  - ALUOp, ALUSrcB and PCSource code constants.
- Sub-module ctrl_output_decode is the combinational state → control-vector decode. The top level keeps the state register, the next-state logic, the counter and the flags.

## Test plan
- Reset is held, then released with opcode=000. Expected:
  - all strobes 0 during reset;
  - INIT, then FETCH showing MemRead=IRWrite=PCWrite=1 and ALUSrcB=01.
- Sequence R, LW, SW, BEQ, J, ADDI. Expected: the exact per-state strobe vectors above, cycle counts 4/5/4/3/3/4, and instr_count=6 at the end.
- opcode=110 at DECODE. Expected: illegal=1, back in FETCH after 2 cycles, instr_count unchanged; illegal stays 1 through later valid instructions.
- opcode=111. Expected: halted=1 and all strobes 0 for 20+ cycles; reset returns to INIT with halted=0.
- reset_n pulsed low during MEMWB of an LW. Expected: RegWrite drops in the same cycle, instr_count=0, restart from INIT.
- instr_count preset by running 65535 ADDIs (or forced to FFFF). One more retire gives instr_count=0000.
